// File: rtl/vedic_mul_seq.sv
// Sequential Vedic multiplier: one CHUNK x CHUNK digit product per clock, shift-accumulated.
// Optional two's-complement support is enabled by defining VEDIC_SIGNED_EN.
module vedic_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int D  = WIDTH / CHUNK;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [CW-1:0]     i_r;
  logic [CW-1:0]     j_r;
  logic [PW-1:0]     acc_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [PW-1:0]     prod_r;
  logic [CHUNK-1:0]  dig_a_s;
  logic [CHUNK-1:0]  dig_b_s;
  logic [PW-1:0]     term_s;
  logic [PW-1:0]     sum_s;
`ifdef VEDIC_SIGNED_EN
  logic              neg_r;
  logic [PW-1:0]     fix_s;
`endif

  function automatic logic [CHUNK-1:0] digit(input logic [WIDTH-1:0] v, input logic [CW-1:0] idx);
    digit = CHUNK'(v >> (CHUNK * idx));
  endfunction

`ifdef VEDIC_SIGNED_EN
  // -2^(WIDTH-1) negates to itself, which is already the correct unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    magnitude = (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  // Current digit pair product, aligned to its weight and added to the running sum
  always_comb begin
    dig_a_s = digit(a_r, i_r);
    dig_b_s = digit(b_r, j_r);
    term_s  = (PW'(dig_a_s) * PW'(dig_b_s)) << (CHUNK * (32'(i_r) + 32'(j_r)));
    sum_s   = acc_r + term_s;
`ifdef VEDIC_SIGNED_EN
    fix_s   = neg_r ? (~acc_r + PW'(1)) : acc_r;
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      i_r         <= '0;
      j_r         <= '0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      prod_r      <= '0;
`ifdef VEDIC_SIGNED_EN
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
`ifdef VEDIC_SIGNED_EN
            a_r   <= magnitude(a, op_signed);
            b_r   <= magnitude(b, op_signed);
            neg_r <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
            a_r   <= a;
            b_r   <= b;
`endif
            acc_r      <= '0;
            i_r        <= '0;
            j_r        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CALC;
          end else begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end

        CALC: begin
          acc_r <= sum_s;
          if (j_r == LAST) begin
            j_r <= '0;
            if (i_r == LAST) begin
`ifdef VEDIC_SIGNED_EN
              state_r <= FIX;
`else
              prod_r      <= sum_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
`endif
            end else begin
              i_r <= i_r + CW'(1);
            end
          end else begin
            j_r <= j_r + CW'(1);
          end
        end

`ifdef VEDIC_SIGNED_EN
        FIX: begin
          acc_r       <= fix_s;
          prod_r      <= fix_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
`endif

        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign prod      = prod_r;
  assign busy      = busy_r;

endmodule
